// File: rtl/data_cache.sv
// Direct-mapped, read-allocate data cache with a line-fill engine for the MEM stage.
// Define DCACHE_STATS_EN to build the saturating hit/miss cycle counters.
module data_cache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic              miss,
  input  logic              update,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int LSB_IDX = 2 + OFF_W;
  localparam int LSB_TAG = LSB_IDX + IDX_W;
  localparam int TAG_W   = ADDR_W - LSB_TAG;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [31:0]       data_q [LINES*LINE_WORDS];

  logic                   data_we_s;
  logic [IDX_W+OFF_W-1:0] data_wa_s;
  logic [31:0]            data_wv_s;
  logic                   tag_we_s;

  logic [IDX_W-1:0] acc_idx_s;
  logic [OFF_W-1:0] acc_off_s;
  logic [TAG_W-1:0] acc_tag_s;
  logic [IDX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic             access_s;
  logic             hit_s;
  logic             miss_s;
  logic             unused_addr_lsb_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      else         res[8*b +: 8] = old_w[8*b +: 8];
    end
    return res;
  endfunction

  assign acc_idx_s         = addr[LSB_IDX +: IDX_W];
  assign acc_off_s         = addr[2 +: OFF_W];
  assign acc_tag_s         = addr[LSB_TAG +: TAG_W];
  assign fill_idx_s        = base_q[LSB_IDX +: IDX_W];
  assign fill_tag_s        = base_q[LSB_TAG +: TAG_W];
  assign unused_addr_lsb_s = ^addr[1:0];

  // A fill in flight blanks both hit and miss so the pipeline only sees the stall.
  assign busy     = (state_q != ST_IDLE);
  assign access_s = rd | wr;
  assign hit_s    = access_s & valid_q[acc_idx_s] & (tag_q[acc_idx_s] == acc_tag_s) & ~busy;
  assign miss_s   = access_s & ~hit_s & ~busy;
  assign hit      = hit_s;
  assign miss     = miss_s;
  assign rdata    = hit_s ? data_q[{acc_idx_s, acc_off_s}] : 32'd0;

  assign mem_req  = (state_q == ST_FILL);
  assign mem_addr = mem_req ? (base_q + {{(ADDR_W-OFF_W-2){1'b0}}, cnt_q, 2'b00})
                            : {ADDR_W{1'b0}};

  // Fill FSM next state plus the single shared data-array write port.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    valid_d   = valid_q;
    tag_we_s  = 1'b0;
    data_we_s = wr & hit_s;
    data_wa_s = {acc_idx_s, acc_off_s};
    data_wv_s = merge_bytes(data_q[{acc_idx_s, acc_off_s}], wdata, wstrb);
    case (state_q)
      ST_IDLE: begin
        if (update) begin
          state_d            = ST_FILL;
          base_d             = {addr[ADDR_W-1:LSB_IDX], {LSB_IDX{1'b0}}};
          cnt_d              = {OFF_W{1'b0}};
          valid_d[acc_idx_s] = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (mem_ack) begin
          data_we_s = 1'b1;
          data_wa_s = {fill_idx_s, cnt_q};
          data_wv_s = mem_rdata;
          cnt_d     = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            valid_d[fill_idx_s] = 1'b1;
            tag_we_s            = 1'b1;
            state_d             = ST_DONE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state; a reset mid-fill abandons the partial line as invalid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= {OFF_W{1'b0}};
      base_q  <= {ADDR_W{1'b0}};
      valid_q <= {LINES{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge CLK) begin
    if (data_we_s) data_q[data_wa_s] <= data_wv_s;
    if (tag_we_s)  tag_q[fill_idx_s] <= fill_tag_s;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating per-cycle event counters.
  always_comb begin
    if (hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    else                                       hit_cnt_d = hit_cnt_q;
    if (miss_s && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    else                                         miss_cnt_d = miss_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random accesses
// and fills, compared against a line-residency model held in associative arrays.
module tb_data_cache;
  localparam int LINES      = 16;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] addr, wdata, mem_rdata;
  logic        rd, wr, update, mem_ack;
  logic [3:0]  wstrb;
  logic [31:0] rdata, mem_addr, hit_cnt, miss_cnt;
  logic        hit, miss, busy, mem_req;

  data_cache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .addr(addr), .rd(rd), .wr(wr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .hit(hit), .miss(miss), .update(update),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference model: which line address each index holds, and the cached word values.
  bit          res_v    [LINES];
  int unsigned res_line [LINES];
  logic [31:0] cwords   [int unsigned];
  logic [31:0] mem_m    [int unsigned];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    else return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic int unsigned line_of(input logic [31:0] a);
    return a / LINE_BYTES;
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return line_of(a) % LINES;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return res_v[idx_of(a)] && (res_line[idx_of(a)] == line_of(a));
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef DCACHE_STATS_EN
    return n;
`else
    return 32'd0 + 0 * n;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) res_v[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // One access cycle: check combinational outputs, then let the edge apply any write.
  task automatic access(input logic [31:0] a, input bit r, input bit w,
                        input logic [3:0] s, input logic [31:0] d);
    logic [31:0] wa, nw, er;
    bit h;
    addr = a; rd = r; wr = w; wstrb = s; wdata = d;
    #1;
    h  = (r | w) && m_hit(a);
    wa = a & 32'hFFFF_FFFC;
    er = 32'd0;
    if (h) er = cwords[int'(wa)];
    check("hit",   {31'd0, hit},  {31'd0, h});
    check("miss",  {31'd0, miss}, {31'd0, (r | w) && !h});
    check("rdata", rdata, er);
    if (h) exp_hits++;
    else if (r | w) exp_misses++;
    @(negedge CLK);
    if (h && w) begin
      nw = cwords[int'(wa)];
      for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
      cwords[int'(wa)] = nw;
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  // Line fill with optional ack gaps and ignored update pulses while busy.
  task automatic do_fill(input logic [31:0] a, input bit gaps);
    logic [31:0] base, wa;
    int waits;
    base = a & ~32'(LINE_BYTES - 1);
    addr = a; update = 1'b1; rd = 1'b0; wr = 1'b0;
    @(negedge CLK);
    update = 1'b0;
    res_v[idx_of(a)] = 1'b0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      waits = 0;
      wa = base + 32'(4 * w);
      forever begin
        rd = 1'($urandom_range(0, 1));
        addr = gaps ? $urandom : a;
        #1;
        check("fill_mem_req",  {31'd0, mem_req}, 32'd1);
        check("fill_mem_addr", mem_addr, wa);
        check("fill_busy",     {31'd0, busy}, 32'd1);
        check("fill_hit",      {31'd0, hit},  32'd0);
        check("fill_miss",     {31'd0, miss}, 32'd0);
        if (!gaps || waits >= 3 || $urandom_range(0, 1) == 1) begin
          mem_ack = 1'b1;
          mem_rdata = mem_val(wa);
          cwords[int'(wa)] = mem_rdata;
          @(negedge CLK);
          mem_ack = 1'b0;
          break;
        end else begin
          update = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
          @(negedge CLK);
          update = 1'b0;
          waits++;
        end
      end
    end
    #1;
    check("done_busy",    {31'd0, busy},    32'd1);
    check("done_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge CLK);
    rd = 1'b0; addr = a;
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    res_v[idx_of(a)] = 1'b1;
    res_line[idx_of(a)] = line_of(a);
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    bit was_hit;
    RST = 1'b1; addr = 32'd0; rd = 1'b0; wr = 1'b0; wstrb = 4'd0; wdata = 32'd0;
    update = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    model_reset();
    for (int i = 0; i < LINE_WORDS; i++) mem_m[32'h100 + 4 * i] = 32'hA0 + i;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_busy",     {31'd0, busy},    32'd0);
    check("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_cnt",  hit_cnt,  32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Cold miss, fill, hit on 0xA2, partial-strobe write merge.
    access(32'h100, 1'b1, 1'b0, 4'h0, 32'd0);
    do_fill(32'h100, 1'b0);
    access(32'h108, 1'b1, 1'b0, 4'h0, 32'd0);
    check("rd_108_val", cwords[32'h108], 32'h0000_00A2);
    access(32'h104, 1'b0, 1'b1, 4'b0011, 32'hFFFF_1234);
    access(32'h104, 1'b1, 1'b0, 4'h0, 32'd0);
    check("merged_104", cwords[32'h104], 32'h0000_1234);

    // Conflict eviction, rd+wr as write, write miss leaves cache unchanged.
    a = 32'h100 + 32'(LINES * LINE_BYTES);
    access(a, 1'b1, 1'b0, 4'h0, 32'd0);
    do_fill(a, 1'b1);
    access(32'h100, 1'b1, 1'b0, 4'h0, 32'd0);
    access(a, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF);
    access(a, 1'b1, 1'b0, 4'h0, 32'd0);
    access(32'h300, 1'b0, 1'b1, 4'hF, 32'h1111_2222);
    access(a, 1'b1, 1'b0, 4'h0, 32'd0);
    access(32'h300, 1'b1, 1'b0, 4'h0, 32'd0);

    // Randomized accesses over four tags, with random fills after misses.
    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      kind = $urandom_range(0, 2);
      was_hit = m_hit(a);
      access(a, kind != 1, kind != 0, 4'($urandom_range(0, 15)), $urandom);
      if (!was_hit && $urandom_range(0, 1) == 1) do_fill(a, 1'b1);
    end
    check("rand_hit_cnt",  hit_cnt,  exp_cnt(exp_hits));
    check("rand_miss_cnt", miss_cnt, exp_cnt(exp_misses));

    // Reset after two of four acks: outputs drop at once, line stays invalid.
    addr = 32'h100; update = 1'b1;
    @(negedge CLK);
    update = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_0000 + w;
      @(negedge CLK);
    end
    mem_ack = 1'b0;
    #1;
    check("midfill_mem_req", {31'd0, mem_req}, 32'd1);
    RST = 1'b1;
    #1;
    check("midrst_mem_req",  {31'd0, mem_req}, 32'd0);
    check("midrst_busy",     {31'd0, busy},    32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_hit_cnt",  hit_cnt,  32'd0);
    check("midrst_miss_cnt", miss_cnt, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();

    // Exactly three hit cycles and two miss cycles since reset.
    access(32'h100, 1'b1, 1'b0, 4'h0, 32'd0);
    do_fill(32'h100, 1'b0);
    access(32'h100, 1'b1, 1'b0, 4'h0, 32'd0);
    access(32'h104, 1'b1, 1'b0, 4'h0, 32'd0);
    access(32'h10C, 1'b1, 1'b0, 4'h0, 32'd0);
    access(32'h500, 1'b1, 1'b0, 4'h0, 32'd0);
    #1;
    check("final_hit_cnt",  hit_cnt,  exp_cnt(3));
    check("final_miss_cnt", miss_cnt, exp_cnt(2));
    check("final_rd_100", cwords[32'h100], 32'h0000_00A0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
